// File: rtl/core_seq_ctrl_if.sv
// core_seq_ctrl_if: handshake/control bundle between the core sequencer and
// the datapath around it (fetch port, load/store port, decoder, strobes).
//   master : the sequencer (drives requests, strobes, halt/err/state)
//   slave  : the surrounding datapath / memory model
interface core_seq_ctrl_if;
  logic       ifu_req;
  logic       ifu_rvalid;
  logic       inst_we;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_ebreak;
  logic       lsu_req;
  logic       lsu_wen;
  logic       lsu_rvalid;
  logic       rf_we;
  logic       pc_we;
  logic       halt;
  logic       err;
  logic [2:0] state;

  modport master (
    output ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we, halt, err, state,
    input  ifu_rvalid, dec_regwrite, dec_memread, dec_memwrite, dec_ebreak,
           lsu_rvalid
  );

  modport slave (
    input  ifu_req, inst_we, lsu_req, lsu_wen, rf_we, pc_we, halt, err, state,
    output ifu_rvalid, dec_regwrite, dec_memread, dec_memwrite, dec_ebreak,
           lsu_rvalid
  );
endinterface

// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer for the NPC core datapath.
// Walks each instruction through FETCH, DECODE, EXEC, (MEM), WB, handshaking
// with the fetch and load/store ports, and owns halt and the memory timeout.
// Ports:
//   clk   : core clock
//   rst   : asynchronous active-low reset
//   bus   : core_seq_ctrl_if.master (fetch/lsu handshakes, decoder controls,
//           inst_we/rf_we/pc_we strobes, halt, err, debug state)
//   cycle_cnt, instret_cnt : performance counters, present only when
//           CORE_SEQ_CTRL_PERF_EN is defined
// Parameters:
//   TIMEOUT : cycles to wait for ifu_rvalid/lsu_rvalid before ERR (0 = never)
//   CNT_W   : performance counter width
module core_seq_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  core_seq_ctrl_if.master      bus
`ifdef CORE_SEQ_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    ERR    = 3'd6,
    IDLE   = 3'd7
  } state_t;

  localparam int              TO_W    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if (TIMEOUT < 0) begin : g_timeout_chk
    $error("TIMEOUT must be non-negative");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("CNT_W must be at least 1");
  end

  state_t          st, st_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            ifu_req_q, lsu_req_q, pc_we_q, halt_q, err_q;

  // Counter value of TIMEOUT-1 means this is the TIMEOUT-th waiting cycle.
  assign to_hit = TO_EN && (to_cnt == TO_LAST);

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:    st_nxt = FETCH;
      FETCH:   if (bus.ifu_rvalid) st_nxt = DECODE;
               else if (to_hit)    st_nxt = ERR;
      DECODE:  st_nxt = bus.dec_ebreak ? HALT : EXEC;
      EXEC:    st_nxt = (bus.dec_memread || bus.dec_memwrite) ? MEM : WB;
      MEM:     if (bus.lsu_rvalid) st_nxt = WB;
               else if (to_hit)    st_nxt = ERR;
      WB:      st_nxt = FETCH;
      default: st_nxt = st;           // HALT and ERR are absorbing
    endcase
  end

  // State, timeout counter and the state-decoded outputs. Outputs are
  // registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      to_cnt    <= '0;
      ifu_req_q <= 1'b0;
      lsu_req_q <= 1'b0;
      pc_we_q   <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      st <= st_nxt;
      if (st_nxt != st)
        to_cnt <= '0;
      else if (st == FETCH || st == MEM)
        to_cnt <= to_cnt + 1'b1;
      ifu_req_q <= (st_nxt == FETCH);
      lsu_req_q <= (st_nxt == MEM);
      pc_we_q   <= (st_nxt == WB);
      halt_q    <= (st_nxt == HALT) || (st_nxt == ERR);
      err_q     <= (st_nxt == ERR);
    end
  end

  assign bus.state   = st;
  assign bus.ifu_req = ifu_req_q;
  assign bus.lsu_req = lsu_req_q;
  assign bus.pc_we   = pc_we_q;
  assign bus.halt    = halt_q;
  assign bus.err     = err_q;
  // These three follow their inputs within the cycle; store wins over load.
  assign bus.inst_we = ifu_req_q & bus.ifu_rvalid;
  assign bus.lsu_wen = lsu_req_q & bus.dec_memwrite;
  assign bus.rf_we   = pc_we_q & bus.dec_regwrite;

`ifdef CORE_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (st == FETCH || st == DECODE || st == EXEC || st == MEM || st == WB)
        cycle_cnt <= cycle_cnt + 1'b1;
      if (st == WB)
        instret_cnt <= instret_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl (TIMEOUT=4): directed instruction table, hand
// sequences for halt/timeout/reset corners, then random stimulus checked
// every cycle against a cycle-level reference model.
module tb_core_seq_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_seq_ctrl_if bus();
`ifdef CORE_SEQ_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  core_seq_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef CORE_SEQ_CTRL_PERF_EN
    ,
    .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt)
`endif
  );

  typedef struct {
    bit rw, mr, mw, eb;
    int idly, ldly;        // waiting cycles before ifu_rvalid / lsu_rvalid
    int len;               // cycles until next FETCH (or halt)
    int rf, pc, lsu, wen;  // strobe cycle counts over the instruction
  } vec_t;

  int n_tests = 0, n_fail = 0;
  int m_st, m_wait;
  int unsigned m_cyc, m_ret;
  int rf_seen, pc_seen, lsu_seen, wen_seen, inst_seen;
  int cyc_no = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc_no);
    end
  endtask

  // Reference model: state number, cycles already spent waiting in it.
  task automatic model_reset();
    m_st = 7; m_wait = 0; m_cyc = 0; m_ret = 0;
  endtask

  function automatic logic [10:0] model_out();
    return {3'(m_st), m_st == 0, (m_st == 0) && bus.ifu_rvalid,
            m_st == 3, (m_st == 3) && bus.dec_memwrite,
            (m_st == 4) && bus.dec_regwrite, m_st == 4,
            (m_st == 5) || (m_st == 6), m_st == 6};
  endfunction

  function automatic logic [10:0] dut_out();
    return {bus.state, bus.ifu_req, bus.inst_we, bus.lsu_req, bus.lsu_wen,
            bus.rf_we, bus.pc_we, bus.halt, bus.err};
  endfunction

  task automatic model_step();
    int nxt;
    bit waited_out;
    nxt = m_st;
    waited_out = (TO != 0) && (m_wait + 1 == TO);
    case (m_st)
      7: nxt = 0;
      0: if (bus.ifu_rvalid) nxt = 1; else if (waited_out) nxt = 6;
      1: nxt = bus.dec_ebreak ? 5 : 2;
      2: nxt = (bus.dec_memread || bus.dec_memwrite) ? 3 : 4;
      3: if (bus.lsu_rvalid) nxt = 4; else if (waited_out) nxt = 6;
      4: nxt = 0;
      default: nxt = m_st;
    endcase
    if (m_st <= 4) m_cyc++;
    if (m_st == 4) m_ret++;
    m_wait = (nxt == m_st) ? m_wait + 1 : 0;
    m_st = nxt;
  endtask

  // One clock: compare at the falling edge, advance model, return at posedge+1.
  task automatic tick(input string nm);
    @(negedge clk);
    if (!rst) model_reset();
    check(nm, 32'(dut_out()), 32'(model_out()));
`ifdef CORE_SEQ_CTRL_PERF_EN
    check({nm, "_cycle_cnt"}, cycle_cnt, m_cyc);
    check({nm, "_instret_cnt"}, instret_cnt, m_ret);
`endif
    if (bus.rf_we)   rf_seen++;
    if (bus.pc_we)   pc_seen++;
    if (bus.lsu_req) lsu_seen++;
    if (bus.lsu_wen) wen_seen++;
    if (bus.inst_we) inst_seen++;
    if (rst) model_step();
    @(posedge clk); #1;
    cyc_no++;
  endtask

  task automatic clear_inputs();
    bus.ifu_rvalid = 0; bus.lsu_rvalid = 0;
    bus.dec_regwrite = 0; bus.dec_memread = 0; bus.dec_memwrite = 0; bus.dec_ebreak = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick("rst_hold");
    check("reset_state", 32'(dut_out()), 32'({3'd7, 8'd0}));
    tick("rst_hold");
    rst = 1'b1;
  endtask

  task automatic clr_seen();
    rf_seen = 0; pc_seen = 0; lsu_seen = 0; wen_seen = 0; inst_seen = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  n;
    bit  left;
    bus.dec_regwrite = v.rw; bus.dec_memread = v.mr;
    bus.dec_memwrite = v.mw; bus.dec_ebreak = v.eb;
    clr_seen();
    n = 0; left = 0;
    do begin
      bus.ifu_rvalid = (m_st == 0) && (m_wait == v.idly);
      bus.lsu_rvalid = (m_st == 3) && (m_wait == v.ldly);
      tick($sformatf("vec%0d", idx));
      n++;
      if (bus.state != 3'd0) left = 1;
    end while (!(left && (bus.state inside {3'd0, 3'd5, 3'd6})) && n < 30);
    bus.ifu_rvalid = 0; bus.lsu_rvalid = 0;
    check($sformatf("vec%0d_len", idx), n, v.len);
    check($sformatf("vec%0d_rf_we", idx), rf_seen, v.rf);
    check($sformatf("vec%0d_pc_we", idx), pc_seen, v.pc);
    check($sformatf("vec%0d_lsu_req", idx), lsu_seen, v.lsu);
    check($sformatf("vec%0d_lsu_wen", idx), wen_seen, v.wen);
  endtask

  vec_t vecs[7];
  int   seq_exp[6];
  logic [2:0] seq_got[6];

  initial begin
    //           rw mr mw eb idly ldly len rf pc lsu wen
    vecs[0] = '{1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0};  // ALU
    vecs[1] = '{1, 1, 0, 0, 0, 3, 8, 1, 1, 4, 0};  // load, rvalid on last allowed cycle
    vecs[2] = '{0, 0, 1, 0, 0, 0, 5, 0, 1, 1, 1};  // store
    vecs[3] = '{1, 1, 1, 0, 0, 1, 6, 1, 1, 2, 2};  // read+write: store wins
    vecs[4] = '{1, 0, 0, 0, 3, 0, 7, 1, 1, 0, 0};  // slow fetch at the timeout edge
    vecs[5] = '{0, 0, 0, 0, 0, 0, 4, 0, 1, 0, 0};  // branch
    vecs[6] = '{1, 0, 0, 1, 0, 0, 2, 0, 0, 0, 0};  // ebreak
    seq_exp = '{7, 0, 1, 2, 4, 0};

    rst = 1'b0;
    clear_inputs();
    model_reset();
    @(posedge clk); #1;

    // ALU op right after reset release: exact state walk
    do_reset();
    bus.dec_regwrite = 1; bus.ifu_rvalid = 1;
    clr_seen();
    for (int i = 0; i < 6; i++) begin
      seq_got[i] = bus.state;
      if (i < 5) tick("alu_first");
    end
    bus.ifu_rvalid = 0;
    for (int i = 0; i < 6; i++) check($sformatf("alu_seq%0d", i), 32'(seq_got[i]), seq_exp[i]);
    check("alu_inst_we", inst_seen, 1);
    check("alu_rf_we", rf_seen, 1);
    check("alu_pc_we", pc_seen, 1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Halt is absorbing; stray strobes do nothing
    clr_seen();
    bus.ifu_rvalid = 1; bus.lsu_rvalid = 1;
    repeat (20) tick("halt_hold");
    check("halt_state", 32'(bus.state), 5);
    check("halt_flag", 32'(bus.halt), 1);
    check("halt_no_pc_we", pc_seen, 0);

    // Fetch timeout: four empty FETCH cycles -> ERR
    do_reset();
    tick("to_idle");
    repeat (4) tick("to_fetch");
    check("to_state", 32'(bus.state), 6);
    check("to_err_halt", 32'({bus.err, bus.halt}), 32'b11);
    // rvalid on the 4th cycle wins over the timeout
    do_reset();
    tick("to2_idle");
    repeat (3) tick("to2_fetch");
    bus.ifu_rvalid = 1;
    tick("to2_fetch");
    bus.ifu_rvalid = 0;
    check("to2_state", 32'(bus.state), 1);
    check("to2_err", 32'(bus.err), 0);

    // Reset pulsed during MEM
    do_reset();
    tick("rm_idle");
    bus.dec_memread = 1; bus.dec_regwrite = 1; bus.ifu_rvalid = 1;
    tick("rm_fetch");
    bus.ifu_rvalid = 0;
    tick("rm_dec");
    tick("rm_exec");
    check("rm_in_mem", 32'(bus.state), 3);
    clr_seen();
    #2 rst = 1'b0;
    #1 check("rm_async", 32'(dut_out()), 32'({3'd7, 8'd0}));
    tick("rm_hold");
    tick("rm_hold");
    rst = 1'b1;
    tick("rm_idle2");
    check("rm_refetch", 32'(bus.state), 0);
    check("rm_no_rf_we", rf_seen, 0);
    check("rm_no_pc_we", pc_seen, 0);

    // Two ALU instructions from reset
    do_reset();
    tick("perf_idle");
    run_vec(vecs[0], 10);
    run_vec(vecs[0], 11);
`ifdef CORE_SEQ_CTRL_PERF_EN
    check("perf_cycle_cnt", cycle_cnt, 8);
    check("perf_instret_cnt", instret_cnt, 2);
`endif

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (!rst) rst = 1'b1;
      else if ((m_st == 5 || m_st == 6) && m_wait >= 3) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      if (m_st == 0 || m_st == 7) begin
        bus.dec_regwrite = 1'($urandom_range(0, 1));
        bus.dec_memread  = 1'($urandom_range(0, 1));
        bus.dec_memwrite = 1'($urandom_range(0, 1));
        bus.dec_ebreak   = ($urandom_range(0, 15) == 0);
      end
      bus.ifu_rvalid = ($urandom_range(0, 9) < 6);
      bus.lsu_rvalid = ($urandom_range(0, 9) < 6);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencing controller for the NPC core datapath. Steps each instruction through fetch, decode, execute, memory and writeback. Handshakes with the instruction fetch port and the load/store port. Consumes the decoder's control outputs (RegWrite, MemRead, MemWrite, ebreak) and generates the instruction-latch, register-file-write and PC-write strobes. Owns core halt and the memory-timeout error.

Parameters:
TIMEOUT, 255, max cycles to wait for ifu_rvalid or lsu_rvalid before ERR; 0 disables timeout
CNT_W, 32, width of performance counters (optional feature only)

Ports:
clk  in  1  core clock
rst  in  1  reset; asynchronous, active-low
ifu_req  out  1  fetch request, level; held until ifu_rvalid
ifu_rvalid  in  1  fetched instruction valid
inst_we  out  1  instruction-register latch strobe
dec_regwrite  in  1  decoder RegWrite
dec_memread  in  1  decoder MemRead
dec_memwrite  in  1  decoder MemWrite
dec_ebreak  in  1  decoder ebreak
lsu_req  out  1  memory access request, level; held until lsu_rvalid
lsu_wen  out  1  1 = store, 0 = load; valid while lsu_req=1
lsu_rvalid  in  1  memory access complete (load data valid or store done)
rf_we  out  1  register-file write strobe
pc_we  out  1  PC update strobe
halt  out  1  core halted (ebreak or error), sticky
err  out  1  timeout error, sticky
state  out  3  current FSM state, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6, IDLE=7.
- While rst=0: state=IDLE, timeout counter=0, all outputs 0.
- Outputs are decoded from state only; the exceptions are inst_we, rf_we and lsu_wen, as noted below.
- IDLE: moves to FETCH unconditionally on the next clk. This is the first cycle after reset release.
- FETCH: ifu_req=1.
  - If ifu_rvalid=1: inst_we=1 in the same cycle, then move to DECODE.
  - Otherwise the timeout counter increments. If the counter equals TIMEOUT-1 and TIMEOUT≠0, move to ERR.
  - If ifu_rvalid and timeout coincide, ifu_rvalid wins.
- DECODE: one cycle. dec_ebreak=1 → HALT; otherwise → EXEC.
- EXEC: one cycle. dec_memread|dec_memwrite → MEM; otherwise → WB.
- MEM: lsu_req=1 and lsu_wen=dec_memwrite. If dec_memread and dec_memwrite are both set, the store takes priority.
  - lsu_rvalid=1 → WB.
  - Timeout works the same way as in FETCH.
- WB: one cycle. pc_we=1, rf_we=dec_regwrite. Then move to FETCH.
- HALT: halt=1. Absorbing; only rst leaves this state.
- ERR: err=1 and halt=1. Absorbing.
- The timeout counter clears on every state change. Its width is clog2(TIMEOUT+1), minimum 1.
- ifu_rvalid and lsu_rvalid are ignored outside FETCH and MEM respectively. A stray strobe has no effect.
- The dec_* inputs are sampled combinationally. They must stay stable from DECODE through WB; the instruction register holds them stable.
- Latency (instruction cycles, FETCH to next FETCH), given one-cycle ifu/lsu response:
  - ALU, branch and jump: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Asserting rst mid-instruction drops to IDLE immediately. No rf_we or pc_we is emitted for the aborted instruction.

Optional Feature:
- Macro CORE_SEQ_CTRL_PERF_EN.
- Defined: adds output ports cycle_cnt[CNT_W] and instret_cnt[CNT_W], both reset to 0.
  - cycle_cnt increments on every clk in states FETCH..WB.
  - instret_cnt increments on every clk in WB.
  - Both wrap modulo 2^CNT_W.
- Undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset release; ifu_rvalid=1 on the first FETCH cycle; ALU op (regwrite=1, no mem) → state sequence 7,0,1,2,4,0; inst_we pulses in cycle 1; rf_we=pc_we=1 in the WB cycle only.
2. Load (memread=1, regwrite=1) with lsu_rvalid delayed 3 cycles → lsu_req high for 4 cycles with lsu_wen=0; then WB with rf_we=1.
3. Store (memwrite=1, regwrite=0) → lsu_wen=1 during MEM; WB has pc_we=1, rf_we=0.
4. ebreak (dec_ebreak=1) → DECODE then HALT; halt=1 and stays 1 for 20 cycles; no pc_we; stray ifu_rvalid is ignored.
5. TIMEOUT=4, ifu_rvalid held 0 → ERR entered after 4 FETCH cycles; err=halt=1. Repeat with rvalid on the 4th cycle → DECODE and no error.
6. rst pulsed low during MEM → outputs 0 asynchronously, no rf_we; after release, FETCH restarts. With CORE_SEQ_CTRL_PERF_EN defined, after two ALU instructions cycle_cnt=8 and instret_cnt=2.
